// File: rtl/state_dump_unit.sv
// state_dump_unit
// Streams a snapshot of CPU state out over a valid/ready channel: one PC
// beat, then every register-file entry, then every data-memory word.
// Register and memory words are read live as each beat is loaded; only
// the PC is captured at the request edge.
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   dump_req_i     start a dump (accepted only while idle)
//   pc_i           program counter, captured at the request edge
//   reg_addr_o     register-file read address (0 unless dumping registers)
//   reg_data_i     register-file read data, combinational from reg_addr_o
//   mem_addr_o     data-memory byte address (0 unless dumping memory)
//   mem_data_i     data-memory read data, combinational from mem_addr_o
//   out_valid_o    output beat valid
//   out_ready_i    sink accepts the beat
//   out_tag_o      beat type: 0 = PC, 1 = REG, 2 = MEM
//   out_idx_o      register or word index (0 for the PC beat)
//   out_data_o     beat payload
//   busy_o         dump in progress
//   done_o         one-cycle pulse after the final beat is accepted
//   dump_count_o   number of completed dumps (wraps)
module state_dump_unit #(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned NUM_MEM  = 32,
   parameter int unsigned DATA_W   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              dump_req_i,
   input  logic [31:0]       pc_i,
   output logic [4:0]        reg_addr_o,
   input  logic [DATA_W-1:0] reg_data_i,
   output logic [31:0]       mem_addr_o,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [1:0]        out_tag_o,
   output logic [4:0]        out_idx_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [15:0]       dump_count_o
);

   localparam int unsigned MaxN = (NUM_REGS > NUM_MEM) ? NUM_REGS : NUM_MEM;
   localparam int unsigned IdxW = (MaxN > 1) ? $clog2(MaxN) : 1;

   localparam logic [IdxW-1:0] RegLast = IdxW'(NUM_REGS - 1);
   localparam logic [IdxW-1:0] MemLast = IdxW'(NUM_MEM - 1);

   localparam logic [1:0] TagPc  = 2'd0;
   localparam logic [1:0] TagReg = 2'd1;
   localparam logic [1:0] TagMem = 2'd2;

   // StReg/StMem: idx_q is the entry to load on the next accepted beat.
   // StLast: the final memory beat is presented and awaits acceptance.
   typedef enum logic [1:0] {
      StIdle,
      StReg,
      StMem,
      StLast
   } state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic                valid_q, valid_d;
   logic [1:0]          tag_q, tag_d;
   logic [4:0]          oidx_q, oidx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                done_q, done_d;
   logic [15:0]         count_q, count_d;
   logic                fire;

   assign fire = valid_q & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         valid_q <= 1'b0;
         tag_q   <= '0;
         oidx_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         oidx_q  <= oidx_d;
         data_q  <= data_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      oidx_d  = oidx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      count_d = count_q;

      unique case (state_q)
         StIdle: begin
            if (dump_req_i) begin
               valid_d = 1'b1;
               tag_d   = TagPc;
               oidx_d  = '0;
               data_d  = DATA_W'(pc_i);
               idx_d   = '0;
               state_d = StReg;
            end
         end
         StReg: begin
            if (fire) begin
               tag_d  = TagReg;
               oidx_d = 5'(idx_q);
               data_d = reg_data_i;
               if (idx_q == RegLast) begin
                  idx_d   = '0;
                  state_d = StMem;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StMem: begin
            if (fire) begin
               tag_d  = TagMem;
               oidx_d = 5'(idx_q);
               data_d = mem_data_i;
               if (idx_q == MemLast) begin
                  idx_d   = '0;
                  state_d = StLast;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StLast: begin
            if (fire) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
               count_d = count_q + 16'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign reg_addr_o   = (state_q == StReg) ? 5'(idx_q) : 5'd0;
   assign mem_addr_o   = (state_q == StMem) ? (32'(idx_q) << 2) : 32'd0;
   assign out_valid_o  = valid_q;
   assign out_tag_o    = tag_q;
   assign out_idx_o    = oidx_q;
   assign out_data_o   = data_q;
   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign dump_count_o = count_q;

endmodule
